// File: rtl/multi_cycle_ctrl.sv
// Main control FSM for the multi-cycle CPU: steps each instruction through
// fetch/decode/execute/memory/writeback and drives every datapath select and strobe.
module multi_cycle_ctrl #(
    parameter logic [5:0] OP_RTYPE = 6'b000000,
    parameter logic [5:0] OP_LW    = 6'b100011,
    parameter logic [5:0] OP_SW    = 6'b101011,
    parameter logic [5:0] OP_BEQ   = 6'b000100,
    parameter logic [5:0] OP_J     = 6'b000010,
    parameter logic [5:0] OP_ADDI  = 6'b001000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ack,
    output logic       mem_req,
    output logic       mem_read,
    output logic       mem_write,
    output logic       i_or_d,
    output logic       ir_write,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic [1:0] pc_source,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       illegal_op,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_IF   = 4'd0,
        S_ID   = 4'd1,
        S_MADR = 4'd2,
        S_MRD  = 4'd3,
        S_MWB  = 4'd4,
        S_MWR  = 4'd5,
        S_EXR  = 4'd6,
        S_RWB  = 4'd7,
        S_BR   = 4'd8,
        S_JMP  = 4'd9,
        S_AEX  = 4'd10,
        S_AWB  = 4'd11
    } state_t;

    state_t cur;
    logic   op_known;

    // zero is consumed by the datapath through pc_write_cond, not by the FSM.
    logic unused_zero;
    assign unused_zero = zero;

    assign state = cur;

    assign op_known = (opcode == OP_RTYPE) || (opcode == OP_LW) || (opcode == OP_SW) ||
                      (opcode == OP_BEQ) || (opcode == OP_J) || (opcode == OP_ADDI);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur <= S_IF;
        end else begin
            case (cur)
                S_IF:   cur <= mem_ack ? S_ID : S_IF;
                S_ID: begin
                    if (opcode == OP_LW || opcode == OP_SW) cur <= S_MADR;
                    else if (opcode == OP_RTYPE)            cur <= S_EXR;
                    else if (opcode == OP_BEQ)              cur <= S_BR;
                    else if (opcode == OP_J)                cur <= S_JMP;
                    else if (opcode == OP_ADDI)             cur <= S_AEX;
                    else                                    cur <= S_IF;
                end
                S_MADR: begin
                    if (opcode == OP_LW)      cur <= S_MRD;
                    else if (opcode == OP_SW) cur <= S_MWR;
                    else                      cur <= S_IF;
                end
                S_MRD:  cur <= mem_ack ? S_MWB : S_MRD;
                S_MWB:  cur <= S_IF;
                S_MWR:  cur <= mem_ack ? S_IF : S_MWR;
                S_EXR:  cur <= S_RWB;
                S_RWB:  cur <= S_IF;
                S_BR:   cur <= S_IF;
                S_JMP:  cur <= S_IF;
                S_AEX:  cur <= S_AWB;
                S_AWB:  cur <= S_IF;
                default: cur <= S_IF;
            endcase
        end
    end

    // Moore decode of the state register; reset low forces every output to 0.
    always_comb begin
        mem_req       = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        i_or_d        = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_source     = 2'b00;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        illegal_op    = 1'b0;
        if (rst_n) begin
            case (cur)
                S_IF: begin
                    mem_req   = 1'b1;
                    mem_read  = 1'b1;
                    alu_src_b = 2'b01;
                    ir_write  = mem_ack;
                    pc_write  = mem_ack;
                end
                S_ID: begin
                    alu_src_b  = 2'b11;
                    illegal_op = ~op_known;
                end
                S_MADR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                end
                S_MRD: begin
                    mem_req  = 1'b1;
                    mem_read = 1'b1;
                    i_or_d   = 1'b1;
                end
                S_MWB: begin
                    mem_to_reg = 1'b1;
                    reg_write  = 1'b1;
                end
                S_MWR: begin
                    mem_req   = 1'b1;
                    mem_write = 1'b1;
                    i_or_d    = 1'b1;
                end
                S_EXR: begin
                    alu_src_a = 1'b1;
                    alu_op    = 2'b10;
                end
                S_RWB: begin
                    reg_dst   = 1'b1;
                    reg_write = 1'b1;
                end
                S_BR: begin
                    alu_src_a     = 1'b1;
                    alu_op        = 2'b01;
                    pc_source     = 2'b01;
                    pc_write_cond = 1'b1;
                end
                S_JMP: begin
                    pc_source = 2'b10;
                    pc_write  = 1'b1;
                end
                S_AEX: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                end
                S_AWB: begin
                    reg_write = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Directed bench for multi_cycle_ctrl: walks each instruction class through the FSM
// and checks state and control outputs cycle by cycle against hand-computed values.
module tb_multi_cycle_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ack;
    logic       mem_req, mem_read, mem_write, i_or_d, ir_write, pc_write, pc_write_cond;
    logic [1:0] pc_source, alu_src_b, alu_op;
    logic       alu_src_a, reg_dst, mem_to_reg, reg_write, illegal_op;
    logic [3:0] state;

    int checks = 0;
    int errors = 0;

    multi_cycle_ctrl dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ack(mem_ack),
        .mem_req(mem_req), .mem_read(mem_read), .mem_write(mem_write), .i_or_d(i_or_d),
        .ir_write(ir_write), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
        .pc_source(pc_source), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .reg_write(reg_write), .illegal_op(illegal_op), .state(state)
    );

    always #5 clk = ~clk;

    // Advance one cycle; inputs change 1 time unit after the edge, checks 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk1(input string tag, input logic got, input logic exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0b exp %0b", tag, got, exp);
        end
    endtask

    task automatic chk2(input string tag, input logic [1:0] got, input logic [1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0b exp %0b", tag, got, exp);
        end
    endtask

    task automatic chk4(input string tag, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    // Strobes that must stay low outside their own states.
    task automatic chk_no_writes(input string tag);
        chk1({tag, ".reg_write"}, reg_write, 1'b0);
        chk1({tag, ".mem_write"}, mem_write, 1'b0);
        chk1({tag, ".pc_write"},  pc_write,  1'b0);
    endtask

    // Fetch with zero-wait ack, ending with the FSM in ID.
    task automatic fetch(input logic [5:0] op);
        opcode  = op;
        mem_ack = 1'b1;
        settle();
        chk4("if.state", state, 4'd0);
        chk1("if.ir_write", ir_write, 1'b1);
        chk1("if.pc_write", pc_write, 1'b1);
        chk2("if.alu_src_b", alu_src_b, 2'b01);
        tick();
        mem_ack = 1'b0;
        settle();
        chk4("id.state", state, 4'd1);
        chk2("id.alu_src_b", alu_src_b, 2'b11);
        chk1("id.illegal_op", illegal_op, 1'b0);
    endtask

    initial begin
        rst_n   = 1'b0;
        opcode  = 6'b000000;
        zero    = 1'b0;
        mem_ack = 1'b1;

        // Reset with mem_ack held high: strobes stay low, state forced to IF.
        tick();
        tick();
        chk4("rst.state", state, 4'd0);
        chk1("rst.mem_req", mem_req, 1'b0);
        chk1("rst.mem_read", mem_read, 1'b0);
        chk1("rst.ir_write", ir_write, 1'b0);
        chk1("rst.pc_write", pc_write, 1'b0);
        chk1("rst.reg_write", reg_write, 1'b0);
        chk1("rst.illegal_op", illegal_op, 1'b0);
        chk2("rst.alu_src_b", alu_src_b, 2'b00);
        rst_n   = 1'b1;
        mem_ack = 1'b0;
        settle();
        chk1("rel.mem_req", mem_req, 1'b1);
        chk1("rel.mem_read", mem_read, 1'b1);
        chk1("rel.ir_write", ir_write, 1'b0);
        tick();
        chk4("rel.hold_if", state, 4'd0);

        // LW, zero-wait: 0,1,2,3,4,0.
        fetch(6'b100011);
        tick();
        chk4("lw.madr", state, 4'd2);
        chk1("lw.alu_src_a", alu_src_a, 1'b1);
        chk2("lw.alu_src_b", alu_src_b, 2'b10);
        tick();
        mem_ack = 1'b1;
        settle();
        chk4("lw.mrd", state, 4'd3);
        chk1("lw.i_or_d", i_or_d, 1'b1);
        chk1("lw.mrd_req", mem_req, 1'b1);
        chk1("lw.mrd_ir_write", ir_write, 1'b0);
        tick();
        mem_ack = 1'b0;
        settle();
        chk4("lw.mwb", state, 4'd4);
        chk1("lw.reg_write", reg_write, 1'b1);
        chk1("lw.mem_to_reg", mem_to_reg, 1'b1);
        chk1("lw.reg_dst", reg_dst, 1'b0);
        tick();
        chk4("lw.done", state, 4'd0);

        // SW with ack delayed 3 cycles in MWR.
        fetch(6'b101011);
        tick();
        chk4("sw.madr", state, 4'd2);
        tick();
        for (int i = 0; i < 4; i++) begin
            mem_ack = (i == 3);
            settle();
            chk4("sw.mwr", state, 4'd5);
            chk1("sw.mem_write", mem_write, 1'b1);
            chk1("sw.i_or_d", i_or_d, 1'b1);
            chk1("sw.reg_write", reg_write, 1'b0);
            chk1("sw.pc_write", pc_write, 1'b0);
            tick();
        end
        mem_ack = 1'b0;
        settle();
        chk4("sw.done", state, 4'd0);

        // BEQ taken then not taken: BR outputs do not depend on zero.
        for (int z = 1; z >= 0; z--) begin
            zero = z[0];
            fetch(6'b000100);
            tick();
            chk4("beq.br", state, 4'd8);
            chk1("beq.pc_write_cond", pc_write_cond, 1'b1);
            chk2("beq.pc_source", pc_source, 2'b01);
            chk2("beq.alu_op", alu_op, 2'b01);
            chk2("beq.alu_src_b", alu_src_b, 2'b00);
            chk_no_writes("beq");
            tick();
            chk4("beq.done", state, 4'd0);
        end

        // J.
        fetch(6'b000010);
        tick();
        chk4("j.jmp", state, 4'd9);
        chk1("j.pc_write", pc_write, 1'b1);
        chk2("j.pc_source", pc_source, 2'b10);
        chk1("j.reg_write", reg_write, 1'b0);
        tick();
        chk4("j.done", state, 4'd0);

        // R-type.
        fetch(6'b000000);
        tick();
        chk4("r.exr", state, 4'd6);
        chk2("r.alu_op", alu_op, 2'b10);
        chk1("r.alu_src_a", alu_src_a, 1'b1);
        chk2("r.alu_src_b", alu_src_b, 2'b00);
        tick();
        chk4("r.rwb", state, 4'd7);
        chk1("r.reg_dst", reg_dst, 1'b1);
        chk1("r.mem_to_reg", mem_to_reg, 1'b0);
        chk1("r.reg_write", reg_write, 1'b1);
        tick();
        chk4("r.done", state, 4'd0);

        // ADDI.
        fetch(6'b001000);
        tick();
        chk4("addi.aex", state, 4'd10);
        chk2("addi.alu_src_b", alu_src_b, 2'b10);
        chk2("addi.alu_op", alu_op, 2'b00);
        tick();
        chk4("addi.awb", state, 4'd11);
        chk1("addi.reg_write", reg_write, 1'b1);
        chk1("addi.reg_dst", reg_dst, 1'b0);
        chk1("addi.mem_to_reg", mem_to_reg, 1'b0);
        tick();
        chk4("addi.done", state, 4'd0);

        // Illegal opcode: one-cycle pulse in ID, then back to IF.
        opcode  = 6'b111111;
        mem_ack = 1'b1;
        settle();
        chk4("ill.if", state, 4'd0);
        tick();
        mem_ack = 1'b0;
        settle();
        chk4("ill.id", state, 4'd1);
        chk1("ill.illegal_op", illegal_op, 1'b1);
        chk_no_writes("ill.id");
        tick();
        chk4("ill.back", state, 4'd0);
        chk1("ill.pulse_end", illegal_op, 1'b0);
        chk1("ill.ir_write", ir_write, 1'b0);

        // Reset during MRD wait; the late ack must not load IR.
        fetch(6'b100011);
        tick();
        tick();
        chk4("rmrd.wait", state, 4'd3);
        tick();
        chk4("rmrd.still", state, 4'd3);
        rst_n = 1'b0;
        settle();
        chk1("rmrd.req_forced", mem_req, 1'b0);
        tick();
        mem_ack = 1'b1;
        settle();
        chk4("rmrd.state", state, 4'd0);
        chk1("rmrd.ir_write", ir_write, 1'b0);
        chk1("rmrd.reg_write", reg_write, 1'b0);
        tick();
        rst_n   = 1'b1;
        mem_ack = 1'b0;
        settle();
        chk4("rmrd.after", state, 4'd0);
        chk1("rmrd.after_ir", ir_write, 1'b0);
        tick();
        chk4("rmrd.idle", state, 4'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multi_cycle_ctrl.md
Name: multi_cycle_ctrl

Overview:
- Main control FSM for the multi-cycle CPU.
- Sequences each instruction through fetch, decode, execute, memory and writeback. Drives every datapath mux select, including the 2:1 select muxes, and the register/memory write strobes.
- Handshakes with the shared instruction/data memory through a req/ack pair.
- Sits between the instruction register's opcode/funct fields and the datapath.

Parameters:
- OP_RTYPE, 6'b000000, R-type opcode
- OP_LW, 6'b100011, load word
- OP_SW, 6'b101011, store word
- OP_BEQ, 6'b000100, branch on equal
- OP_J, 6'b000010, jump
- OP_ADDI, 6'b001000, add immediate

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  synchronous reset, active-low
- opcode  input  6  IR[31:26]
- zero  input  1  ALU zero flag
- mem_ack  input  1  memory transfer complete, single-cycle pulse
- mem_req  output  1  memory access request
- mem_read  output  1  read access
- mem_write  output  1  write access
- i_or_d  output  1  address select: 0 = PC, 1 = ALUOut
- ir_write  output  1  IR load strobe
- pc_write  output  1  unconditional PC load
- pc_write_cond  output  1  PC load if zero
- pc_source  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- alu_src_a  output  1  0 = PC, 1 = register A
- alu_src_b  output  2  00 = B, 01 = const 4, 10 = sext imm, 11 = sext imm<<2
- alu_op  output  2  00 = add, 01 = sub, 10 = decode funct
- reg_dst  output  1  0 = rt, 1 = rd
- mem_to_reg  output  1  0 = ALUOut, 1 = MDR
- reg_write  output  1  register file write strobe
- illegal_op  output  1  one-cycle pulse on undefined opcode
- state  output  4  current state, for debug

Behaviour:
State register and encodings:
- 4-bit state register; encodings: IF = 0, ID = 1, MADR = 2, MRD = 3, MWB = 4, MWR = 5, EXR = 6, RWB = 7, BR = 8, JMP = 9, AEX = 10, AWB = 11.
- Outputs are Moore-decoded from state. Exceptions: ir_write and pc_write in IF are additionally qualified by mem_ack.

Reset:
- rst_n low at a clk edge forces state = IF.
- While rst_n is low, all strobes are forced to 0: mem_req, mem_read, mem_write, ir_write, pc_write, pc_write_cond, reg_write, illegal_op.
- All selects read 0 during reset; state reads 0 after the edge.
- Reset mid-transfer abandons the access; a mem_ack arriving after reset is ignored unless the FSM is again in IF/MRD/MWR.

IF:
- mem_req = 1, mem_read = 1, i_or_d = 0, alu_src_a = 0, alu_src_b = 01, alu_op = 00, pc_source = 00.
- Hold in IF while mem_ack = 0.
- On mem_ack: ir_write = 1 and pc_write = 1 in that same cycle; next state = ID.

ID:
- alu_src_a = 0, alu_src_b = 11, alu_op = 00 (branch target into ALUOut).
- Next state by opcode: LW/SW → MADR, RTYPE → EXR, BEQ → BR, J → JMP, ADDI → AEX.
- Any other opcode → illegal_op = 1 for this cycle, next state = IF.

Memory path:
- MADR: alu_src_a = 1, alu_src_b = 10, alu_op = 00. Next state MRD for LW, MWR for SW (opcode held stable by IR).
- MRD: mem_req = 1, mem_read = 1, i_or_d = 1. Hold until mem_ack, then go to MWB.
- MWB: reg_dst = 0, mem_to_reg = 1, reg_write = 1. Next state IF.
- MWR: mem_req = 1, mem_write = 1, i_or_d = 1. Hold until mem_ack, then go to IF.

R-type and ADDI:
- EXR: alu_src_a = 1, alu_src_b = 00, alu_op = 10. Next state RWB.
- RWB: reg_dst = 1, mem_to_reg = 0, reg_write = 1. Next state IF.
- AEX: alu_src_a = 1, alu_src_b = 10, alu_op = 00. Next state AWB.
- AWB: reg_dst = 0, mem_to_reg = 0, reg_write = 1. Next state IF.

Control flow:
- BR: alu_src_a = 1, alu_src_b = 00, alu_op = 01, pc_source = 01, pc_write_cond = 1. Next state IF.
- JMP: pc_source = 10, pc_write = 1. Next state IF.

General rules:
- Unused selects are 0 in every state.
- reg_write, mem_write and pc_write are never asserted in the same cycle.
- Undefined state encodings (12–15) → next state IF, all strobes 0.
- mem_ack outside IF/MRD/MWR is ignored.
- Cycle counts with zero-wait memory (ack in the first cycle of each access):
  - LW = 5
  - SW = 4
  - R-type = 4
  - ADDI = 4
  - BEQ = 3
  - J = 3
- Each memory wait cycle adds 1.

Test Plan:
- Reset: rst_n = 0 for 2 cycles, mem_ack = 1 → state = 0, all strobes 0. Release → mem_req = 1 in IF.
- LW, ack in the first cycle of IF and MRD: state sequence 0, 1, 2, 3, 4, 0 → ir_write/pc_write pulse in cycle 1; reg_write = 1 with mem_to_reg = 1, reg_dst = 0 in cycle 5.
- SW with mem_ack delayed 3 cycles in MWR → stays in state 5 for 4 cycles with mem_write = 1; reg_write never 1.
- BEQ with zero = 1, then zero = 0 → states 0, 1, 8. pc_write_cond = 1, pc_source = 01, alu_op = 01 in state 8 both times; pc_write = 0.
- Opcode 6'b111111 → illegal_op pulses for 1 cycle in ID, next state 0, no write strobes.
- rst_n dropped during MRD wait, with mem_ack arriving the next cycle → state = 0. No reg_write; that mem_ack does not trigger ir_write.
